// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: opcode/ALU-op encodings and sequencer state shared by the execute-stage slice
package exec_sequencer_pkg;
   localparam int OPC_W = 8;
   localparam int ALU_W = 8;
   typedef enum logic [1:0] {
      SEQ_IDLE     = 2'd0,
      SEQ_VALID    = 2'd1,
      SEQ_MUL_BUSY = 2'd2
   } seq_state_e;
   localparam logic [OPC_W-1:0] OPCODE_ADD      = 8'h01;
   localparam logic [OPC_W-1:0] OPCODE_SUB      = 8'h02;
   localparam logic [OPC_W-1:0] OPCODE_MUL      = 8'h03;
   localparam logic [OPC_W-1:0] OPCODE_LDB      = 8'h04;
   localparam logic [OPC_W-1:0] OPCODE_LDW      = 8'h05;
   localparam logic [OPC_W-1:0] OPCODE_STB      = 8'h06;
   localparam logic [OPC_W-1:0] OPCODE_STW      = 8'h07;
   localparam logic [OPC_W-1:0] OPCODE_MOV      = 8'h08;
   localparam logic [OPC_W-1:0] OPCODE_BEQ      = 8'h09;
   localparam logic [OPC_W-1:0] OPCODE_JUMP     = 8'h0A;
   localparam logic [OPC_W-1:0] OPCODE_TLBWRITE = 8'h0B;
   localparam logic [OPC_W-1:0] OPCODE_IRET     = 8'h0C;
   localparam logic [ALU_W-1:0] ALUOP_ADD       = 8'h21;
   localparam logic [ALU_W-1:0] ALUOP_SUB       = 8'h22;
   localparam logic [ALU_W-1:0] ALUOP_MUL       = 8'h23;
   localparam logic [ALU_W-1:0] ALUOP_LDB       = 8'h24;
   localparam logic [ALU_W-1:0] ALUOP_LDW       = 8'h25;
   localparam logic [ALU_W-1:0] ALUOP_STB       = 8'h26;
   localparam logic [ALU_W-1:0] ALUOP_STW       = 8'h27;
   localparam logic [ALU_W-1:0] ALUOP_MOV       = 8'h28;
   localparam logic [ALU_W-1:0] ALUOP_BEQ       = 8'h29;
   localparam logic [ALU_W-1:0] ALUOP_JUMP      = 8'h2A;
   localparam logic [ALU_W-1:0] ALUOP_TLBWRITE  = 8'h2B;
   localparam logic [ALU_W-1:0] ALUOP_IRET      = 8'h2C;
endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: ID/EX input handshake, flush and MEM-side valid/ready output of the sequencer
interface exec_sequencer_if
   import exec_sequencer_pkg::*;
#(
   parameter int OPCODE_W = OPC_W,
   parameter int ALUOP_W  = ALU_W
);
   logic                in_valid;
   logic [OPCODE_W-1:0] in_opcode;
   logic                in_ready;
   logic                stall_out;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [ALUOP_W-1:0]  aluop_out;
   logic                illegal_op;
   modport master (
      output in_valid, in_opcode, flush, out_ready,
      input  in_ready, stall_out, out_valid, aluop_out, illegal_op
   );
   modport slave (
      input  in_valid, in_opcode, flush, out_ready,
      output in_ready, stall_out, out_valid, aluop_out, illegal_op
   );
endinterface

// File: rtl/exec_sequencer_alucontrol.sv
// alucontrol: opcode to ALU-operation decode; anything outside the table is flagged illegal with aluop 0
module alucontrol
   import exec_sequencer_pkg::*;
#(
   parameter int OPCODE_W = OPC_W,
   parameter int ALUOP_W  = ALU_W
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [ALUOP_W-1:0]  aluop,
   output logic                illegal
);
   always_comb begin
      aluop   = '0;
      illegal = 1'b0;
      case (opcode)
         OPCODE_ADD:      aluop = ALUOP_ADD;
         OPCODE_SUB:      aluop = ALUOP_SUB;
         OPCODE_MUL:      aluop = ALUOP_MUL;
         OPCODE_LDB:      aluop = ALUOP_LDB;
         OPCODE_LDW:      aluop = ALUOP_LDW;
         OPCODE_STB:      aluop = ALUOP_STB;
         OPCODE_STW:      aluop = ALUOP_STW;
         OPCODE_MOV:      aluop = ALUOP_MOV;
         OPCODE_BEQ:      aluop = ALUOP_BEQ;
         OPCODE_JUMP:     aluop = ALUOP_JUMP;
         OPCODE_TLBWRITE: aluop = ALUOP_TLBWRITE;
         OPCODE_IRET:     aluop = ALUOP_IRET;
         default:         illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: sequences the ALU per instruction; single-cycle ops retire next cycle, MUL after
// MUL_LATENCY cycles, with a one-entry valid/ready output to MEM and a stall to the hazard unit.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int MUL_LATENCY = 5,
   parameter int OPCODE_W    = OPC_W,
   parameter int ALUOP_W     = ALU_W
) (
   input  logic                clk,
   input  logic                reset,
   exec_sequencer_if.slave     bus,
   output logic                mul_start,
   output logic                mul_busy,
   output logic [15:0]         op_count
);
   localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 2);
   seq_state_e         state, state_n;
   logic [3:0]         cnt;
   logic [ALUOP_W-1:0] dec_aluop;
   logic               dec_illegal;
   logic               is_mul;
   logic               accept;
   alucontrol #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_dec (
      .opcode  (bus.in_opcode),
      .aluop   (dec_aluop),
      .illegal (dec_illegal)
   );
   assign is_mul        = bus.in_opcode == OPCODE_MUL;
   assign bus.in_ready  = (state == SEQ_IDLE) | ((state == SEQ_VALID) & bus.out_ready);
   assign bus.stall_out = ~bus.in_ready;
   assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
   assign bus.out_valid = state == SEQ_VALID;
   assign mul_busy      = state == SEQ_MUL_BUSY;
   // flush outranks everything; an accept is only possible from IDLE or a draining VALID
   always_comb begin
      state_n = state;
      state_n = bus.flush ? SEQ_IDLE :
                accept ? (is_mul ? SEQ_MUL_BUSY : SEQ_VALID) :
                (state == SEQ_MUL_BUSY) ? ((cnt == '0) ? SEQ_VALID : SEQ_MUL_BUSY) :
                (state == SEQ_VALID) ? (bus.out_ready ? SEQ_IDLE : SEQ_VALID) :
                state;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= SEQ_IDLE;
         cnt            <= '0;
         bus.aluop_out  <= '0;
         bus.illegal_op <= 1'b0;
         mul_start      <= 1'b0;
         op_count       <= '0;
      end else begin
         state     <= state_n;
         mul_start <= accept & is_mul;
         cnt       <= bus.flush ? '0 :
                      (accept & is_mul) ? CNT_INIT :
                      ((state == SEQ_MUL_BUSY) && (cnt != '0)) ? cnt - 4'd1 :
                      cnt;
         if (accept) begin
            bus.aluop_out  <= dec_aluop;
            bus.illegal_op <= dec_illegal;
         end
         if (bus.out_valid & bus.out_ready & ~bus.flush)
            op_count <= op_count + 16'd1;
      end
   end
endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Execute-stage controller that sequences the ALU for each instruction handed over by the ID/EX register.
- Decodes opcode to ALU operation, runs single-cycle ops in one cycle and MUL over MUL_LATENCY cycles.
- Back-pressures decode with a stall while busy, and presents a one-entry valid/ready output to the MEM stage.
- Sits between ID/EX and the ALU/MEM handoff; drives the hazard unit's stall input.

Parameters:
- MUL_LATENCY, 5, cycles from MUL acceptance to out_valid; legal range 2..16.
- OPCODE_W, 8, opcode width.
- ALUOP_W, 8, ALU operation code width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  ID/EX holds a valid instruction.
- in_opcode  input  OPCODE_W  opcode of that instruction (OPCODE_* from define.v).
- in_ready  output  1  sequencer accepts this cycle (combinational).
- stall_out  output  1  equals ~in_ready; to hazard unit.
- flush  input  1  kill in-flight and held work (exception, taken branch, IRET).
- out_valid  output  1  aluop_out and illegal_op valid for MEM.
- out_ready  input  1  MEM consumes the output this cycle.
- aluop_out  output  ALUOP_W  registered ALU operation (ALUOP_* from define.v).
- illegal_op  output  1  registered; held opcode is not in the decode set.
- mul_start  output  1  one-cycle pulse to the multiplier, in the cycle after a MUL is accepted.
- mul_busy  output  1  high while state is MUL_BUSY.
- op_count  output  16  count of retired outputs.

Behaviour:
- Reset (async) clears everything: state=IDLE, out_valid=0, aluop_out=0, illegal_op=0, mul_start=0, cnt=0, op_count=0.
- State IDLE: nothing held.
- State VALID: output held, out_valid=1.
- State MUL_BUSY: multiply in progress, out_valid=0.
- in_ready = (state==IDLE) | (state==VALID & out_ready). The output drains and refills in the same cycle.
- accept = in_valid & in_ready & ~flush.
- Decode uses the same mapping as the ALU control table: ADD, SUB, MUL, LDB, LDW, STB, STW, MOV, BEQ, JUMP, TLBWRITE, IRET map to their ALUOP_* codes.
- Unknown opcode: aluop_out=0, illegal_op=1, treated as a single-cycle op. Simulation-only WARNING macro.
- accept of a non-MUL op in cycle N: aluop_out and illegal_op load, state goes to VALID, out_valid=1 in cycle N+1.
- accept of MUL in cycle N:
  - aluop_out=ALUOP_MUL loads, cnt=MUL_LATENCY-2, state goes to MUL_BUSY.
  - mul_start=1 in cycle N+1 only.
- In MUL_BUSY: if cnt==0, state goes to VALID; otherwise cnt decrements. Result: out_valid=1 in cycle N+MUL_LATENCY.
- VALID & out_ready & ~accept: state goes to IDLE, out_valid=0 next cycle.
- VALID & ~out_ready: output and state hold; in_ready=0.
- flush has highest priority:
  - Next cycle: state=IDLE, out_valid=0, cnt=0, mul_start=0.
  - Any input in the flush cycle is not accepted, even if in_ready was high.
  - aluop_out holds its value; don't-care.
- op_count increments on out_valid & out_ready & ~flush. It wraps 0xFFFF to 0x0000; there is no saturation.
- Reset mid-MUL: immediate return to the reset values; no mul_start is emitted afterwards.
- All outputs except in_ready and stall_out are registered.

Decomposition:
- Shared define.v holds OPCODE_*, ALUOP_*, WARNING macro, and new state encodings SEQ_IDLE=2'd0, SEQ_VALID=2'd1, SEQ_MUL_BUSY=2'd2.
- Instantiate the existing alucontrol as the decode sub-module.
- Add an is_mul compare and an illegal-opcode detect alongside it; no other sub-modules.

Test Plan:
- Reset: assert reset mid-cycle with in_valid=1 and opcode ADD -> all outputs 0 immediately; op_count=0.
- ADD accepted in cycle 10 with out_ready=1 -> out_valid=1 and aluop_out=ALUOP_ADD in cycle 11; back-to-back SUB accepted in cycle 11 -> ALUOP_SUB valid in cycle 12; op_count=2.
- MUL accepted in cycle 20, MUL_LATENCY=5:
  - mul_start=1 in cycle 21 only; mul_busy=1 in cycles 21-24; stall_out=1 in cycles 21-24.
  - out_valid=1 with ALUOP_MUL in cycle 25.
- Backpressure: LDW held with out_ready=0 for 3 cycles -> out_valid stays 1, aluop_out stable, in_ready=0; STB not accepted until out_ready=1.
- Flush: flush in cycle 23 of the MUL above -> out_valid stays 0 in cycle 25, mul_busy=0 from cycle 24; new ADD accepted in cycle 24 yields out_valid in cycle 25.
- Opcode 0xFF -> illegal_op=1, aluop_out=0, single-cycle latency; preload op_count=0xFFFF, retire one -> op_count=0x0000.
